csa_param_bridge: RTL and testbench
===================================

Name: csa_param_bridge

Overview:
Host-side endpoint of the CSA calc-logic parameter interface. Packs a stream of 32-bit host words into one 160-bit request record and pushes it into the calc-logic input FIFO (csa_in_wen/csa_in/csa_in_full). Pops 224-bit result records from the output FIFO (csa_out_ready/csa_out_ren/csa_out) and serves them back as 32-bit words. Sits between the AXI register slave and the calc-logic wrapper.

Parameters:
AXI_DATA_WIDTH, 32, host word width.
IN_WORDS, 5, words per request record.
OUT_WORDS, 7, words per result record.
CSA_IN_PARAMETER_LENGTH, AXI_DATA_WIDTH*IN_WORDS, request record width.
CSA_OUT_PARAMETER_LENGTH, AXI_DATA_WIDTH*OUT_WORDS, result record width.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
host_wen  in  1  host word write strobe
host_wdata  in  AXI_DATA_WIDTH  host write word
host_wready  out  1  bridge can accept a word this cycle
host_flush  in  1  discard partially assembled or pending request
host_ren  in  1  host consumes current read word
host_rvalid  out  1  host_rdata valid
host_rdata  out  AXI_DATA_WIDTH  current result word
csa_in_full  in  1  input FIFO full
csa_in_wen  out  1  push request record
csa_in  out  CSA_IN_PARAMETER_LENGTH  request record
csa_out_ready  in  1  output FIFO has data
csa_out_ren  out  1  pop result record
csa_out  in  CSA_OUT_PARAMETER_LENGTH  result record (valid one clk after csa_out_ren)
req_count  out  32  requests pushed, wraps
rsp_count  out  32  results fully drained, wraps

Behaviour:
- Reset: rst_n synchronous, active-low, clock clk. While rst_n==0 all outputs 0; assembly/holding regs, indices, counters cleared; write FSM W_FILL, read FSM R_IDLE.
- Request word order (LSB first): w0 block, w1 in[31:0], w2 in[63:32], w3 times, w4 times_start; word k occupies csa_in[32k+31:32k].
- Write FSM W_FILL: host_wready=1; host_wen stores host_wdata at wr_idx; wr_idx++; on wr_idx==IN_WORDS-1 -> W_PUSH, wr_idx=0. host_wen while host_wready==0 ignored.
- W_PUSH: host_wready=0; csa_in_wen = !csa_in_full (combinational), one cycle, then -> W_FILL and req_count++. Full holds in W_PUSH indefinitely; csa_in stable throughout.
- Latency: last word accepted cycle N -> csa_in_wen at N+1 if not full; next host word accepted N+2.
- host_flush: priority over host_wen and push; forces csa_in_wen=0 that cycle, wr_idx=0, -> W_FILL, assembly reg unchanged (don't-care), req_count unchanged. Read side unaffected.
- Read FSM R_IDLE: if csa_out_ready, csa_out_ren=1 (one cycle) -> R_WAIT.
- R_WAIT: capture csa_out into holding reg, rd_idx=0 -> R_DRAIN. csa_out_ren=0.
- R_DRAIN: host_rvalid=1, host_rdata=hold[32*rd_idx+:32]; host_ren advances rd_idx; host_ren at rd_idx==OUT_WORDS-1 -> R_IDLE, rsp_count++. host_ren while host_rvalid==0 ignored.
- Result word order: w0 block, w1/w2 in, w3 times, w4 times_start, w5 out[31:0], w6 out[63:32].
- Min pop-to-pop spacing: 1 (ren) + 1 (capture) + 7 drain cycles; csa_out_ren never asserted in R_WAIT/R_DRAIN.
- Write and read paths independent; simultaneous push and pop allowed.
- Counters wrap 0xFFFFFFFF -> 0.
- Reset mid-record: partial request and undrained result lost; no csa_in_wen/csa_out_ren during or first cycle after reset.

Decomposition:
- Package csa_bridge_pkg: AXI_DATA_WIDTH, IN_WORDS, OUT_WORDS, word index constants (W_BLOCK=0, W_IN_LO=1, W_IN_HI=2, W_TIMES=3, W_TIMES_START=4, W_OUT_LO=5, W_OUT_HI=6), FSM state encodings.
- One sub-module: csa_result_unpacker (read FSM, holding reg, rd_idx, rsp_count); write path stays in top.

Test Plan:
- Write 0x1,0x11223344,0x55667788,0x10,0x2, csa_in_full=0 -> csa_in_wen one cycle after 5th word, csa_in=0x00000002_00000010_55667788_11223344_00000001, req_count=1.
- Same with csa_in_full=1 for 20 cycles -> host_wready=0, csa_in_wen=0 for 20 cycles, csa_in stable; single push on cycle full drops, req_count=1.
- Write 3 words, pulse host_flush, write 5 words A..E -> one push with csa_in words A..E only.
- csa_out_ready=1, csa_out words 0..6 = 0x100..0x106 -> one csa_out_ren pulse; host_rdata 0x100..0x106 over 7 host_ren; rsp_count=1; no second ren before drain ends.
- host_ren held low 50 cycles in R_DRAIN -> host_rvalid stays 1, host_rdata=0x100, csa_out_ren stays 0.
- Assert rst_n=0 after 2 request words and 3 result words -> all outputs 0, counters 0; fresh 5-word write afterwards pushes exactly the new words.

Source files
------------

// File: rtl/csa_bridge_pkg.sv
// Shared constants, record word indices and FSM encodings for the CSA parameter bridge.
package csa_bridge_pkg;

  localparam int AXI_DATA_WIDTH           = 32;
  localparam int IN_WORDS                 = 5;
  localparam int OUT_WORDS                = 7;
  localparam int CSA_IN_PARAMETER_LENGTH  = AXI_DATA_WIDTH * IN_WORDS;
  localparam int CSA_OUT_PARAMETER_LENGTH = AXI_DATA_WIDTH * OUT_WORDS;

  localparam int IN_IDX_W  = $clog2(IN_WORDS);
  localparam int OUT_IDX_W = $clog2(OUT_WORDS);

  // Word positions inside the request / result records, LSB word first.
  localparam int W_BLOCK       = 0;
  localparam int W_IN_LO       = 1;
  localparam int W_IN_HI       = 2;
  localparam int W_TIMES       = 3;
  localparam int W_TIMES_START = 4;
  localparam int W_OUT_LO      = 5;
  localparam int W_OUT_HI      = 6;

  typedef enum logic {
    W_FILL = 1'b0,
    W_PUSH = 1'b1
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/csa_result_unpacker.sv
// Read side of the bridge: pops one result record from the calc-logic output FIFO
// and serves it to the host one 32-bit word at a time.
module csa_result_unpacker
  import csa_bridge_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                csa_out_ready,
  output logic                                csa_out_ren,
  input  logic [CSA_OUT_PARAMETER_LENGTH-1:0] csa_out,
  input  logic                                host_ren,
  output logic                                host_rvalid,
  output logic [AXI_DATA_WIDTH-1:0]           host_rdata,
  output logic [31:0]                         rsp_count
);

  rd_state_e                               r_state;
  rd_state_e                               w_next;
  logic                                    r_live;
  logic [OUT_WORDS-1:0][AXI_DATA_WIDTH-1:0] r_hold;
  logic [OUT_IDX_W-1:0]                    r_rd_idx;
  logic [31:0]                             r_rsp_count;
  logic                                    w_pop;
  logic                                    w_capture;
  logic                                    w_advance;
  logic                                    w_last;
  logic                                    w_rvalid;

  // r_live keeps the FIFO untouched during the first cycle after reset release.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_advance = 1'b0;
    w_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (csa_out_ready && r_live) begin
          w_pop  = 1'b1;
          w_next = R_WAIT;
        end
      end
      R_WAIT: begin
        w_capture = 1'b1;
        w_next    = R_DRAIN;
      end
      R_DRAIN: begin
        w_rvalid = 1'b1;
        if (host_ren) begin
          w_advance = 1'b1;
          if (r_rd_idx == OUT_IDX_W'(W_OUT_HI)) w_next = R_IDLE;
        end
      end
      default: w_next = R_IDLE;
    endcase
  end

  assign w_last = w_advance && (r_rd_idx == OUT_IDX_W'(W_OUT_HI));

  // NOTE: the holding register is reset so a result lost to reset can never be re-served.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_rd_idx    <= '0;
      r_rsp_count <= '0;
    end else begin
      if (w_capture) begin
        r_hold   <= csa_out;
        r_rd_idx <= '0;
      end else if (w_advance) begin
        r_rd_idx <= w_last ? '0 : r_rd_idx + OUT_IDX_W'(1);
      end
      if (w_last) r_rsp_count <= r_rsp_count + 32'd1;
    end
  end

  assign csa_out_ren = rst_n && w_pop;
  assign host_rvalid = rst_n && w_rvalid;
  assign host_rdata  = host_rvalid ? r_hold[r_rd_idx] : '0;
  assign rsp_count   = rst_n ? r_rsp_count : '0;

endmodule

// File: rtl/csa_param_bridge.sv
// Host-side endpoint of the CSA parameter interface: packs host words into request
// records for the calc-logic input FIFO and unpacks result records back to the host.
module csa_param_bridge
  import csa_bridge_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                host_wen,
  input  logic [AXI_DATA_WIDTH-1:0]           host_wdata,
  output logic                                host_wready,
  input  logic                                host_flush,
  input  logic                                host_ren,
  output logic                                host_rvalid,
  output logic [AXI_DATA_WIDTH-1:0]           host_rdata,
  input  logic                                csa_in_full,
  output logic                                csa_in_wen,
  output logic [CSA_IN_PARAMETER_LENGTH-1:0]  csa_in,
  input  logic                                csa_out_ready,
  output logic                                csa_out_ren,
  input  logic [CSA_OUT_PARAMETER_LENGTH-1:0] csa_out,
  output logic [31:0]                         req_count,
  output logic [31:0]                         rsp_count
);

  wr_state_e                               r_wr_state;
  wr_state_e                               w_wr_next;
  logic [IN_IDX_W-1:0]                     r_wr_idx;
  logic [IN_WORDS-1:0][AXI_DATA_WIDTH-1:0] r_asm;
  logic [31:0]                             r_req_count;
  logic                                    w_store;
  logic                                    w_last_word;
  logic                                    w_push;
  logic                                    w_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) r_wr_state <= W_FILL;
    else        r_wr_state <= w_wr_next;
  end

  // Flush outranks both a host write and a pending push.
  always_comb begin
    w_wr_next = r_wr_state;
    w_ready   = 1'b0;
    w_store   = 1'b0;
    w_push    = 1'b0;
    case (r_wr_state)
      W_FILL: begin
        w_ready = 1'b1;
        w_store = host_wen && !host_flush;
        if (w_store && r_wr_idx == IN_IDX_W'(W_TIMES_START)) w_wr_next = W_PUSH;
      end
      W_PUSH: begin
        if (host_flush) begin
          w_wr_next = W_FILL;
        end else if (!csa_in_full) begin
          w_push    = 1'b1;
          w_wr_next = W_FILL;
        end
      end
      default: w_wr_next = W_FILL;
    endcase
  end

  assign w_last_word = w_store && (r_wr_idx == IN_IDX_W'(W_TIMES_START));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_idx    <= '0;
      r_asm       <= '0;
      r_req_count <= '0;
    end else begin
      if (host_flush || w_last_word) r_wr_idx <= '0;
      else if (w_store)              r_wr_idx <= r_wr_idx + IN_IDX_W'(1);
      if (w_store) r_asm[r_wr_idx] <= host_wdata;
      if (w_push)  r_req_count <= r_req_count + 32'd1;
    end
  end

  assign host_wready = rst_n && w_ready;
  assign csa_in_wen  = rst_n && w_push;
  assign csa_in      = rst_n ? r_asm : '0;
  assign req_count   = rst_n ? r_req_count : '0;

  csa_result_unpacker u_unpacker (
    .clk           (clk),
    .rst_n         (rst_n),
    .csa_out_ready (csa_out_ready),
    .csa_out_ren   (csa_out_ren),
    .csa_out       (csa_out),
    .host_ren      (host_ren),
    .host_rvalid   (host_rvalid),
    .host_rdata    (host_rdata),
    .rsp_count     (rsp_count)
  );

endmodule

// File: tb/tb_csa_param_bridge.sv
// Scoreboard bench for csa_param_bridge: directed cases plus a randomized phase
// against a queue-based reference model of the request/result record streams.
module tb_csa_param_bridge;
  import csa_bridge_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         host_wen = 1'b0;
  logic [31:0]  host_wdata = '0;
  logic         host_wready;
  logic         host_flush = 1'b0;
  logic         host_ren = 1'b0;
  logic         host_rvalid;
  logic [31:0]  host_rdata;
  logic         csa_in_full = 1'b0;
  logic         csa_in_wen;
  logic [159:0] csa_in;
  logic         csa_out_ready = 1'b0;
  logic         csa_out_ren;
  logic [223:0] csa_out = '0;
  logic [31:0]  req_count;
  logic [31:0]  rsp_count;

  csa_param_bridge dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host_wen      (host_wen),
    .host_wdata    (host_wdata),
    .host_wready   (host_wready),
    .host_flush    (host_flush),
    .host_ren      (host_ren),
    .host_rvalid   (host_rvalid),
    .host_rdata    (host_rdata),
    .csa_in_full   (csa_in_full),
    .csa_in_wen    (csa_in_wen),
    .csa_in        (csa_in),
    .csa_out_ready (csa_out_ready),
    .csa_out_ren   (csa_out_ren),
    .csa_out       (csa_out),
    .req_count     (req_count),
    .rsp_count     (rsp_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0]  pend[$];
  logic [159:0] exp_req[$];
  logic [31:0]  exp_rsp[$];
  logic [223:0] csa_fifo[$];
  logic [31:0]  exp_req_count = '0;
  logic [31:0]  exp_rsp_count = '0;
  int           rd_words = 0;
  int           push_seen = 0;
  int           ren_seen_cnt = 0;
  int           cyc = 0;
  int           last_ren_cyc = -100;
  bit           ren_seen = 1'b0;
  bit           full_auto = 1'b0;
  bit           rd_auto = 1'b0;

  task automatic check(input string name, input logic [223:0] got, input logic [223:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [223:0] make_result(input logic [31:0] base, input bit rnd);
    logic [223:0] r;
    for (int k = 0; k < OUT_WORDS; k++) r[32*k +: 32] = rnd ? $urandom : base + 32'(k);
    return r;
  endfunction

  task automatic host_write(input logic [31:0] w);
    int n;
    logic [159:0] rec;
    n = 0;
    @(negedge clk);
    while (!host_wready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("wready_timeout", host_wready, 1);
    host_wen   = 1'b1;
    host_wdata = w;
    pend.push_back(w);
    if (pend.size() == IN_WORDS) begin
      for (int k = 0; k < IN_WORDS; k++) rec[32*k +: 32] = pend[k];
      exp_req.push_back(rec);
      pend.delete();
    end
    @(posedge clk);
    #1 host_wen = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    host_flush = 1'b1;
    pend.delete();
    @(posedge clk);
    #1 host_flush = 1'b0;
  endtask

  task automatic wait_rvalid();
    int n;
    n = 0;
    @(negedge clk);
    while (!host_rvalid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("rvalid_timeout", host_rvalid, 1);
  endtask

  task automatic wait_idle();
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < 5000) begin
      @(negedge clk);
      done = (exp_req.size() == 0) && (exp_rsp.size() == 0) && (csa_fifo.size() == 0) && !host_rvalid && !ren_seen;
      n++;
    end
    check("drain_done", done, 1);
  endtask

  // Request monitor
  always @(negedge clk) begin
    if (rst_n && csa_in_wen) begin
      push_seen++;
      check("push_expected", exp_req.size() != 0, 1);
      if (exp_req.size() != 0) check("csa_in", csa_in, exp_req.pop_front());
      check("req_count_pre_push", req_count, exp_req_count);
      exp_req_count++;
    end
  end

  // Result monitor
  always @(negedge clk) begin
    if (rst_n && host_rvalid && host_ren) begin
      check("rdata_expected", exp_rsp.size() != 0, 1);
      if (exp_rsp.size() != 0) check("host_rdata", host_rdata, exp_rsp.pop_front());
      rd_words++;
      if (rd_words % OUT_WORDS == 0) begin
        check("rsp_count_pre_done", rsp_count, exp_rsp_count);
        exp_rsp_count++;
      end
    end
  end

  // Output-FIFO model: pop observed, data presented one cycle after the pop
  always @(negedge clk) begin
    if (csa_out_ren) begin
      ren_seen_cnt++;
      check("ren_has_data", csa_fifo.size() != 0, 1);
      check("ren_spacing_ok", (cyc - last_ren_cyc) >= 9, 1);
      last_ren_cyc = cyc;
      ren_seen     = 1'b1;
    end
  end

  always @(posedge clk) begin
    logic [223:0] rec;
    cyc++;
    #1;
    if (ren_seen) begin
      ren_seen = 1'b0;
      if (csa_fifo.size() != 0) begin
        rec     = csa_fifo.pop_front();
        csa_out = rec;
        for (int k = 0; k < OUT_WORDS; k++) exp_rsp.push_back(rec[32*k +: 32]);
      end
    end
    csa_out_ready = (csa_fifo.size() != 0);
    if (full_auto) csa_in_full = ($urandom_range(0, 3) == 0);
    if (rd_auto)   host_ren = ($urandom_range(0, 1) == 1);
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_wready"}, host_wready, 0);
    check({tag, "_rvalid"}, host_rvalid, 0);
    check({tag, "_rdata"}, host_rdata, 0);
    check({tag, "_in_wen"}, csa_in_wen, 0);
    check({tag, "_csa_in"}, csa_in, 0);
    check({tag, "_out_ren"}, csa_out_ren, 0);
    check({tag, "_req_count"}, req_count, 0);
    check({tag, "_rsp_count"}, rsp_count, 0);
  endtask

  initial begin
    int p0;
    logic [31:0] wl[5];

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("wready_after_reset", host_wready, 1);

    // Basic request packing and one-cycle push latency
    host_write(32'h1);
    host_write(32'h11223344);
    host_write(32'h55667788);
    host_write(32'h10);
    host_write(32'h2);
    @(negedge clk);
    check("wen_after_last_word", csa_in_wen, 1);
    check("csa_in_packed", csa_in, 160'h00000002_00000010_55667788_11223344_00000001);
    check("wready_in_push", host_wready, 0);
    @(negedge clk);
    check("wen_single_cycle", csa_in_wen, 0);
    check("req_count_1", req_count, 1);

    // Back-pressure from a full input FIFO
    p0 = push_seen;
    host_write(32'hA1);
    host_write(32'hA2);
    host_write(32'hA3);
    host_write(32'hA4);
    csa_in_full = 1'b1;
    host_write(32'hA5);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (host_wready !== 1'b0 || csa_in_wen !== 1'b0 ||
          csa_in !== 160'h000000A5_000000A4_000000A3_000000A2_000000A1) begin
        check("full_hold", {host_wready, csa_in_wen, csa_in}, {2'b00, 160'h000000A5_000000A4_000000A3_000000A2_000000A1});
      end
    end
    check("full_no_push", push_seen - p0, 0);
    @(posedge clk);
    #1 csa_in_full = 1'b0;
    @(negedge clk);
    check("push_on_full_drop", csa_in_wen, 1);
    @(negedge clk);
    check("full_single_push", push_seen - p0, 1);
    check("req_count_2", req_count, 2);

    // Flush discards a partial record
    p0 = push_seen;
    host_write(32'hDEAD0001);
    host_write(32'hDEAD0002);
    host_write(32'hDEAD0003);
    do_flush();
    wl = '{32'hAAAA0000, 32'hBBBB1111, 32'hCCCC2222, 32'hDDDD3333, 32'hEEEE4444};
    for (int i = 0; i < 5; i++) host_write(wl[i]);
    repeat (3) @(negedge clk);
    check("flush_one_push", push_seen - p0, 1);
    check("req_count_3", req_count, 3);

    // Result drain with the host stalling 50 cycles on the first word
    host_ren = 1'b0;
    csa_fifo.push_back(make_result(32'h100, 1'b0));
    wait_rvalid();
    csa_fifo.push_back(make_result(32'h200, 1'b0));
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (host_rvalid !== 1'b1 || host_rdata !== 32'h100 || csa_out_ren !== 1'b0)
        check("stall_hold", {host_rvalid, host_rdata, csa_out_ren}, {1'b1, 32'h100, 1'b0});
    end
    check("one_ren_during_stall", ren_seen_cnt, 1);
    rd_auto = 1'b1;
    wait_idle();
    check("rsp_count_2", rsp_count, 2);
    check("ren_count_2", ren_seen_cnt, 2);

    // Reset in the middle of a request and a result
    rd_auto = 1'b0;
    @(posedge clk);
    #2 host_ren = 1'b0;
    host_write(32'h77770000);
    host_write(32'h77770001);
    csa_fifo.push_back(make_result(32'h300, 1'b0));
    wait_rvalid();
    @(posedge clk);
    #2 host_ren = 1'b1;
    repeat (3) @(posedge clk);
    #2 host_ren = 1'b0;
    rst_n = 1'b0;
    pend.delete();
    exp_rsp.delete();
    rd_words      = 0;
    exp_req_count = '0;
    exp_rsp_count = '0;
    csa_fifo.push_back(make_result(32'h400, 1'b0));
    repeat (2) @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("no_ren_first_cycle", csa_out_ren, 0);
    check("no_wen_first_cycle", csa_in_wen, 0);
    p0 = push_seen;
    for (int i = 0; i < 5; i++) host_write(32'h5A5A0000 + 32'(i));
    rd_auto = 1'b1;
    wait_idle();
    check("post_reset_one_push", push_seen - p0, 1);
    check("post_reset_req_count", req_count, 1);
    check("post_reset_rsp_count", rsp_count, 1);

    // Randomized traffic on both paths
    full_auto = 1'b1;
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 1) == 1) csa_fifo.push_back(make_result(32'h0, 1'b1));
      for (int k = 0; k < IN_WORDS; k++) begin
        host_write($urandom);
        if (pend.size() > 0 && $urandom_range(0, 7) == 0) do_flush();
      end
    end
    while (pend.size() != 0) host_write($urandom);
    wait_idle();
    full_auto = 1'b0;
    csa_in_full = 1'b0;
    repeat (2) @(negedge clk);
    check("final_req_count", req_count, exp_req_count);
    check("final_rsp_count", rsp_count, exp_rsp_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
